// File: rtl/logic_unit_monitor.sv
// logic_unit_monitor
//   Response-side checker for the 32-bit LogicUnit. Each valid transaction seen
//   on the LogicUnit boundary is registered (stage 1), then the expected result
//   is recomputed from the registered operands and compared with the registered
//   actual result (stage 2). Transactions and mismatches are counted, the first
//   failing transaction is captured, and done/pass rise once NUM_TXN
//   transactions have been checked.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              one-cycle pulse: arm (or re-arm) and clear all results
//   in_valid           A/B/S/logicModuleOutput form a valid transaction
//   A, B, S            operands and select driven to the LogicUnit
//   logicModuleOutput  LogicUnit result, same cycle as A/B/S
//   busy, done, pass   run status (pass = done with no mismatches)
//   mismatch           one-cycle pulse when a checked transaction failed
//   txn_count          transactions checked since start
//   err_count          mismatches since start, saturating
//   fail_A/B/S         operands and select of the first failure
//   fail_exp/fail_act  expected and actual result of the first failure
module logic_unit_monitor #(
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 16,
   parameter int NUM_TXN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       S,
   input  logic [WIDTH-1:0] logicModuleOutput,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] err_count,
   output logic [WIDTH-1:0] fail_A,
   output logic [WIDTH-1:0] fail_B,
   output logic [1:0]       fail_S,
   output logic [WIDTH-1:0] fail_exp,
   output logic [WIDTH-1:0] fail_act
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TXN - 1);

   state_t           state;
   logic [WIDTH-1:0] opA_p1;
   logic [WIDTH-1:0] opB_p1;
   logic [1:0]       sel_p1;
   logic [WIDTH-1:0] act_p1;
   logic             vld_p1;
   logic [WIDTH-1:0] exp_p1;
   logic             miss_p1;
   logic             lastCmp;

   function automatic logic [WIDTH-1:0] logicOp(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       s);
      case (s)
         2'b00:   logicOp = a & b;
         2'b01:   logicOp = a | b;
         2'b10:   logicOp = a ^ b;
         default: logicOp = ~(a | b);
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
      satInc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

   // ---- stage 2: compare registered transaction ----
   always_comb begin
      exp_p1  = logicOp(opA_p1, opB_p1, sel_p1);
      miss_p1 = vld_p1 && (exp_p1 != act_p1);
      // The compare that brings txn_count to NUM_TXN ends the run.
      lastCmp = vld_p1 && (txn_count == LAST_CNT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         vld_p1    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         mismatch  <= 1'b0;
         txn_count <= '0;
         err_count <= '0;
         fail_A    <= '0;
         fail_B    <= '0;
         fail_S    <= '0;
         fail_exp  <= '0;
         fail_act  <= '0;
      end else if (start) begin
         // Start wins over any capture or compare on the same edge.
         state     <= RUN;
         vld_p1    <= 1'b0;
         busy      <= 1'b1;
         done      <= 1'b0;
         pass      <= 1'b0;
         mismatch  <= 1'b0;
         txn_count <= '0;
         err_count <= '0;
         fail_A    <= '0;
         fail_B    <= '0;
         fail_S    <= '0;
         fail_exp  <= '0;
         fail_act  <= '0;
      end else begin
         mismatch <= 1'b0;
         case (state)
            RUN: begin
               if (vld_p1) begin
                  txn_count <= txn_count + CNT_W'(1);
                  if (miss_p1) begin
                     mismatch  <= 1'b1;
                     err_count <= satInc(err_count);
                     if (err_count == '0) begin
                        fail_A   <= opA_p1;
                        fail_B   <= opB_p1;
                        fail_S   <= sel_p1;
                        fail_exp <= exp_p1;
                        fail_act <= act_p1;
                     end
                  end
               end
               if (lastCmp) begin
                  // Anything arriving on this edge is beyond the programmed count.
                  state  <= DONE;
                  vld_p1 <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  pass   <= (err_count == '0) && !miss_p1;
               end else begin
                  // ---- stage 1: capture LogicUnit boundary ----
                  vld_p1 <= in_valid;
                  if (in_valid) begin
                     opA_p1 <= A;
                     opB_p1 <= B;
                     sel_p1 <= S;
                     act_p1 <= logicModuleOutput;
                  end
               end
            end
            default: vld_p1 <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_monitor.sv
module tb_logic_unit_monitor;

   localparam int WIDTH   = 32;
   localparam int CNT_W   = 16;
   localparam int NUM_TXN = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic [1:0]       S = '0;
   logic [WIDTH-1:0] logicModuleOutput = '0;
   logic             busy, done, pass, mismatch;
   logic [CNT_W-1:0] txn_count, err_count;
   logic [WIDTH-1:0] fail_A, fail_B, fail_exp, fail_act;
   logic [1:0]       fail_S;

   logic_unit_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .NUM_TXN(NUM_TXN)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .A(A), .B(B), .S(S), .logicModuleOutput(logicModuleOutput),
      .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
      .txn_count(txn_count), .err_count(err_count),
      .fail_A(fail_A), .fail_B(fail_B), .fail_S(fail_S),
      .fail_exp(fail_exp), .fail_act(fail_act)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [WIDTH-1:0] txA [8];
   logic [WIDTH-1:0] txB [8];
   logic [1:0]       txS [8];
   logic [WIDTH-1:0] txAct [8];

   function automatic logic [WIDTH-1:0] refOp(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] s);
      case (s)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setTxn(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] s, input logic [WIDTH-1:0] act);
      txA[i] = a; txB[i] = b; txS[i] = s; txAct[i] = act;
   endtask

   task automatic setGood(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] s);
      setTxn(i, a, b, s, refOp(a, b, s));
   endtask

   task automatic pulseStart();
      start = 1'b1; in_valid = 1'b0;
      tick();
      start = 1'b0;
   endtask

   task automatic drive(input int i);
      in_valid = 1'b1;
      A = txA[i]; B = txB[i]; S = txS[i]; logicModuleOutput = txAct[i];
   endtask

   // Start a run, stream n transactions back to back, then check per-cycle
   // results and the final outcome against the transaction list.
   task automatic runTxns(input int n, input string tag);
      int m, expErr, firstBad;
      logic bad;
      pulseStart();
      check({tag, ":busyArm"}, busy, 1);
      for (int i = 0; i <= n; i++) begin
         if (i < n) drive(i);
         else in_valid = 1'b0;
         tick();
         if (i >= 1 && i <= NUM_TXN) begin
            bad = (txAct[i-1] != refOp(txA[i-1], txB[i-1], txS[i-1]));
            check($sformatf("%s:mismatch%0d", tag, i), mismatch, bad);
            check($sformatf("%s:txn%0d", tag, i), txn_count, i);
            check($sformatf("%s:done%0d", tag, i), done, (i == NUM_TXN));
         end
      end
      in_valid = 1'b0;
      tick(); tick();
      m = (n < NUM_TXN) ? n : NUM_TXN;
      expErr = 0; firstBad = -1;
      for (int i = 0; i < m; i++)
         if (txAct[i] != refOp(txA[i], txB[i], txS[i])) begin
            expErr++;
            if (firstBad < 0) firstBad = i;
         end
      check({tag, ":txnFinal"}, txn_count, m);
      check({tag, ":errFinal"}, err_count, expErr);
      check({tag, ":doneFinal"}, done, 1);
      check({tag, ":busyFinal"}, busy, 0);
      check({tag, ":passFinal"}, pass, (expErr == 0));
      if (firstBad >= 0) begin
         check({tag, ":failA"}, fail_A, txA[firstBad]);
         check({tag, ":failB"}, fail_B, txB[firstBad]);
         check({tag, ":failS"}, fail_S, txS[firstBad]);
         check({tag, ":failExp"}, fail_exp, refOp(txA[firstBad], txB[firstBad], txS[firstBad]));
         check({tag, ":failAct"}, fail_act, txAct[firstBad]);
      end else begin
         check({tag, ":failExpClr"}, fail_exp, 0);
         check({tag, ":failActClr"}, fail_act, 0);
      end
   endtask

   task automatic loadPlan();
      setGood(0, 32'h0000FFFF, 32'h00000F0F, 2'b00);
      setGood(1, 32'h0000FFFF, 32'h00000F0F, 2'b01);
      setGood(2, 32'h0000FFFF, 32'h00000F0F, 2'b10);
      setGood(3, 32'h0000FFFF, 32'h0000FFFF, 2'b11);
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, ":busy"}, busy, 0);
      check({tag, ":done"}, done, 0);
      check({tag, ":pass"}, pass, 0);
      check({tag, ":mismatch"}, mismatch, 0);
      check({tag, ":txn"}, txn_count, 0);
      check({tag, ":err"}, err_count, 0);
      check({tag, ":failA"}, fail_A, 0);
      check({tag, ":failS"}, fail_S, 0);
      check({tag, ":failExp"}, fail_exp, 0);
      check({tag, ":failAct"}, fail_act, 0);
   endtask

   initial begin
      logic bad;
      // Reset state, and in_valid before start is ignored.
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checkAllZero("reset");
      loadPlan();
      drive(0); tick(); drive(1); tick(); tick();
      in_valid = 1'b0;
      check("idleTxn", txn_count, 0);
      check("idleBusy", busy, 0);

      // Four correct transactions.
      loadPlan();
      check("planRes3", txAct[3], 32'hFFFF0000);
      runTxns(4, "good");
      check("goodPassConst", pass, 1);

      // Result forced to zero on S=01.
      loadPlan();
      txAct[1] = 32'h00000000;
      runTxns(4, "oneErr");
      check("oneErrS", fail_S, 2'b01);
      check("oneErrExp", fail_exp, 32'h0000FFFF);
      check("oneErrPass", pass, 0);

      // Two errors: first capture held.
      loadPlan();
      txAct[0] = 32'hDEADBEEF;
      txAct[2] = 32'h00000000;
      runTxns(4, "twoErr");
      check("twoErrCnt", err_count, 2);
      check("twoErrExp", fail_exp, 32'h00000F0F);

      // in_valid held for six cycles: extra ones ignored.
      loadPlan();
      setGood(4, 32'h12345678, 32'h0F0F0F0F, 2'b00);
      setTxn(5, 32'h1, 32'h2, 2'b01, 32'h0);
      runTxns(6, "over");

      // Randomised runs, including re-arm from DONE.
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(4, 6);
         for (int i = 0; i < n; i++) begin
            logic [WIDTH-1:0] a, b, fl;
            logic [1:0] s;
            a = $urandom; b = $urandom; s = 2'($urandom_range(0, 3));
            fl = $urandom | 32'h1;
            bad = ($urandom_range(0, 3) == 0);
            setTxn(i, a, b, s, bad ? (refOp(a, b, s) ^ fl) : refOp(a, b, s));
         end
         runTxns(n, $sformatf("rand%0d", r));
      end

      // Reset mid-run after two transactions (one failing).
      loadPlan();
      txAct[0] = 32'h0;
      pulseStart();
      drive(0); tick(); drive(1); tick();
      in_valid = 1'b0; tick();
      check("midRunTxn", txn_count, 2);
      check("midRunErr", err_count, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      checkAllZero("midRst");
      loadPlan();
      runTxns(4, "afterRst");

      // Restart during RUN coinciding with the third compare.
      loadPlan();
      txAct[1] = 32'hFFFFFFFF;
      pulseStart();
      drive(0); tick(); drive(1); tick(); drive(2); tick();
      check("restartPreErr", err_count, 1);
      start = 1'b1; in_valid = 1'b0; tick(); start = 1'b0;
      check("restartBusy", busy, 1);
      check("restartTxn", txn_count, 0);
      check("restartErr", err_count, 0);
      check("restartFailS", fail_S, 0);
      check("restartFailAct", fail_act, 0);
      tick();
      check("restartFlushed", txn_count, 0);
      loadPlan();
      runTxns(4, "afterRestart");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/logic_unit_monitor.md
Name: logic_unit_monitor

Overview:
- Response-side checker for the 32-bit LogicUnit (operands A/B, select S, result logicModuleOutput).
- Samples each valid transaction on the LogicUnit boundary and recomputes the expected result internally, one pipeline stage later.
- Counts transactions and mismatches and captures the first failing transaction.
- Raises done/pass once a programmed number of transactions has been checked; sits beside the LogicUnit in simulation and FPGA self-test builds.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 16, width of transaction and error counters.
- NUM_TXN, 4, transactions to check before done asserts (1..2^CNT_W-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; arms the monitor, clears counters and capture registers.
- in_valid  input  1  A/B/S/logicModuleOutput are a valid transaction this cycle.
- A  input  WIDTH  operand A driven to LogicUnit.
- B  input  WIDTH  operand B driven to LogicUnit.
- S  input  2  operation select driven to LogicUnit.
- logicModuleOutput  input  WIDTH  LogicUnit result (combinational, same cycle as A/B/S).
- busy  output  1  monitor armed and counting.
- done  output  1  NUM_TXN transactions checked.
- pass  output  1  done and err_count==0.
- mismatch  output  1  one-cycle pulse: transaction checked this cycle failed.
- txn_count  output  CNT_W  transactions checked since start.
- err_count  output  CNT_W  mismatches since start, saturating.
- fail_A / fail_B  output  WIDTH  operands of first failing transaction.
- fail_S  output  2  select of first failure.
- fail_exp / fail_act  output  WIDTH  expected and actual result of first failure.

Behaviour:
- Operation encoding: S=00 A&B; 01 A|B; 10 A^B; 11 ~(A|B).
- Reset (rst=1 at clk edge): state IDLE; all outputs 0, including counters, capture registers, mismatch, done and pass. rst overrides start and in_valid, including mid-run; any in-flight pipeline stage is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(txn_count reaches NUM_TXN on the compare edge)--> DONE.
  - DONE --start--> RUN.
  - start while in RUN restarts the run: counters and capture cleared, pipeline stage flushed, remains RUN.
- busy=1 only in RUN. done=1 only in DONE. pass = done & (err_count==0), registered.
- Stage 1 (capture): in RUN with in_valid=1, register A, B, S, logicModuleOutput and set v1. in_valid is ignored in IDLE and DONE.
- Stage 2 (compare): when v1=1, compute the expected result from the registered A/B/S and compare to the registered result.
  - txn_count increments.
  - On inequality: mismatch pulses; err_count increments (holds at 2^CNT_W-1).
  - If err_count was 0 before this compare, load fail_* registers. Later failures never overwrite them.
- Latency: in_valid at edge N -> mismatch/txn_count update visible after edge N+1. done visible after the edge on which the NUM_TXN-th compare occurs.
- Back-to-back in_valid every cycle is supported at full rate.
- Once txn_count reaches NUM_TXN, the next state is DONE. A stage-1 transaction still pending at that point is discarded and not counted. txn_count never exceeds NUM_TXN.
- start coincident with a compare: start wins; counters end at 0.
- Arithmetic: all comparisons are full WIDTH bitwise equality; no X-propagation handling beyond simulator default.

Test Plan:
- Reset, then start, then 4 txns on a correct LogicUnit: A=0000FFFF, B=00000F0F with S=00/01/10, then A=B=0000FFFF with S=11 -> expected 00000F0F, 0000FFFF, 0000F0F0, FFFF0000. txn_count=4, err_count=0, done=1, pass=1 one cycle after the 4th compare.
- Same stimulus with result forced to 00000000 on S=01 -> mismatch pulse two edges after that in_valid. err_count=1, fail_S=01, fail_exp=0000FFFF, fail_act=00000000, pass=0 at done.
- Two injected errors (S=00 then S=10) -> err_count=2; fail_* still hold the S=00 transaction (fail_exp=00000F0F).
- in_valid held high for 6 cycles with NUM_TXN=4 -> txn_count stops at 4, DONE entered, extra transactions ignored. in_valid before start is ignored (txn_count=0, busy=0).
- rst asserted mid-run after 2 txns -> next cycle all outputs 0, state IDLE. A following start plus 4 good txns gives pass=1.
- start pulsed during RUN after 3 txns, one of them failing -> counters and fail_* cleared. 4 further good txns give pass=1.
